midi_rx_parser: RTL and testbench

MIDI_RX_PARSER -- requirements
Module: midi_rx_parser

---
 rtl/midi_pkg.sv | 26 ++
 rtl/midi_rx_parser_if.sv | 24 ++
 rtl/uart_rx_8n1.sv | 104 ++++++++++
 rtl/midi_rx_parser.sv | 138 +++++++++++++
 tb/tb_midi_rx_parser.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/midi_pkg.sv
// Shared MIDI definitions.
// Holds the status-nibble constants, the width of one queued note event and
// the packed record that the parser writes into the event queue.
package midi_pkg;

  localparam logic [3:0] NOTE_OFF = 4'h8;
  localparam logic [3:0] NOTE_ON  = 4'h9;
  localparam logic [3:0] PROG     = 4'hC;
  localparam logic [3:0] CHPRES   = 4'hD;

  localparam int EVENT_W = 19;

  // MSB first: is_on, channel, velocity, note (1 + 4 + 7 + 7 = EVENT_W bits)
  typedef struct packed {
    logic       is_on;
    logic [3:0] channel;
    logic [6:0] velocity;
    logic [6:0] note;
  } midi_event_t;

  // Program change and channel pressure carry a single data byte.
  function automatic logic is_single_data(input logic [3:0] status_hi);
    return (status_hi == PROG) || (status_hi == CHPRES);
  endfunction

endpackage

// File: rtl/midi_rx_parser_if.sv
// Note-event stream from the parser's queue to its consumer.
// Handshake: the producer raises ev_valid while the queue head is valid and
// keeps every head field stable until the cycle in which ev_valid and
// ev_ready are both high; that cycle transfers the head. ev_ready may be
// driven freely by the consumer and has no effect while ev_valid is low.
//   ev_valid    : head holds an event
//   ev_ready    : consumer accepts the head
//   ev_note     : key number
//   ev_velocity : velocity
//   ev_channel  : MIDI channel
//   ev_is_on    : 1 = note-on, 0 = note-off
interface midi_rx_parser_if;
  logic       ev_valid;
  logic       ev_ready;
  logic [6:0] ev_note;
  logic [6:0] ev_velocity;
  logic [3:0] ev_channel;
  logic       ev_is_on;

  modport master (output ev_valid, ev_note, ev_velocity, ev_channel, ev_is_on,
                  input  ev_ready);
  modport slave  (input  ev_valid, ev_note, ev_velocity, ev_channel, ev_is_on,
                  output ev_ready);
endinterface

// File: rtl/uart_rx_8n1.sv
// 8N1 serial byte receiver with a 2-flop input synchronizer.
//   clk, reset    : clock, asynchronous active-high reset
//   rx            : raw serial line, idle high, LSB first
//   rx_byte       : last correctly framed byte
//   rx_ready      : one-cycle pulse per correctly framed byte
//   framing_error : one-cycle pulse when the stop bit samples 0
//   state_dbg     : receiver state (IDLE/START/DATA/STOP)
// BIT_TICKS is clock cycles per bit and must be at least 16.
module uart_rx_8n1 #(
  parameter int BIT_TICKS = 3200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] rx_byte,
  output logic       rx_ready,
  output logic       framing_error,
  output logic [1:0] state_dbg
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  localparam int             CW        = $clog2(BIT_TICKS);
  localparam logic [CW-1:0]  FULL_LOAD = CW'(BIT_TICKS - 1);
  localparam logic [CW-1:0]  HALF_LOAD = CW'(BIT_TICKS / 2 - 1);

  logic [1:0]    sync_q;
  logic          rx_s;
  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
  logic          wait_high;  // bad stop bit seen; hold off until the line idles

  assign rx_s      = sync_q[1];
  assign state_dbg = state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q        <= 2'b11;
      state         <= S_IDLE;
      cnt           <= '0;
      bit_idx       <= '0;
      shift         <= '0;
      wait_high     <= 1'b0;
      rx_byte       <= '0;
      rx_ready      <= 1'b0;
      framing_error <= 1'b0;
    end else begin
      sync_q        <= {sync_q[0], rx};
      rx_ready      <= 1'b0;
      framing_error <= 1'b0;
      case (state)
        S_IDLE: begin
          if (!rx_s) begin
            state <= S_START;
            cnt   <= HALF_LOAD;
          end
        end
        S_START: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else if (!rx_s) begin
            state   <= S_DATA;
            cnt     <= FULL_LOAD;
            bit_idx <= '0;
          end else begin
            state <= S_IDLE;  // start glitch, drop silently
          end
        end
        S_DATA: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            shift   <= {rx_s, shift[7:1]};
            cnt     <= FULL_LOAD;
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == 3'd7) state <= S_STOP;
          end
        end
        S_STOP: begin
          if (wait_high) begin
            if (rx_s) begin
              wait_high <= 1'b0;
              state     <= S_IDLE;
            end
          end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else if (rx_s) begin
            rx_byte  <= shift;
            rx_ready <= 1'b1;
            state    <= S_IDLE;
          end else begin
            framing_error <= 1'b1;
            wait_high     <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: rtl/midi_rx_parser.sv
// MIDI input: serial receiver, channel-message parser and note-event queue.
//   clk, reset        : clock, asynchronous active-high reset
//   uart_rx           : MIDI serial line (8N1, idle high)
//   ev                : note-event stream (see midi_rx_parser_if)
//   overflow          : pulse when an event is dropped on a full queue
//   framing_error     : pulse when a stop bit samples 0
//   debug_uart_byte   : last correctly framed byte
//   debug_uart_ready  : pulse per correctly framed byte
//   debug_rx_state    : receiver state
//   debug_parse_state : parser state (WAIT_STATUS/DATA1/DATA2)
module midi_rx_parser
  import midi_pkg::*;
#(
  parameter int          CLOCK_FREQ   = 100_000_000,
  parameter int          BAUD_RATE    = 31250,
  parameter logic [15:0] CHANNEL_MASK = 16'hFFFF,
  parameter int          FIFO_DEPTH   = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   uart_rx,
  midi_rx_parser_if.master       ev,
  output logic                   overflow,
  output logic                   framing_error,
  output logic [7:0]             debug_uart_byte,
  output logic                   debug_uart_ready,
  output logic [1:0]             debug_rx_state,
  output logic [1:0]             debug_parse_state
);
  localparam int BIT_TICKS = CLOCK_FREQ / BAUD_RATE;
  localparam int AW        = $clog2(FIFO_DEPTH);

  localparam logic [1:0] P_WAIT  = 2'd0;
  localparam logic [1:0] P_DATA1 = 2'd1;
  localparam logic [1:0] P_DATA2 = 2'd2;

  logic [7:0]  rx_byte;
  logic        rx_ready;
  logic [1:0]  pstate;
  logic [7:0]  running_status;  // 0 = no running status
  logic [3:0]  rs_hi;
  logic [6:0]  data1;
  logic        wr_en;
  midi_event_t wr_data;

  uart_rx_8n1 #(.BIT_TICKS(BIT_TICKS)) u_rx (
    .clk           (clk),
    .reset         (reset),
    .rx            (uart_rx),
    .rx_byte       (rx_byte),
    .rx_ready      (rx_ready),
    .framing_error (framing_error),
    .state_dbg     (debug_rx_state)
  );

  assign debug_uart_byte   = rx_byte;
  assign debug_uart_ready  = rx_ready;
  assign debug_parse_state = pstate;
  assign rs_hi             = running_status[7:4];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pstate         <= P_WAIT;
      running_status <= '0;
      data1          <= '0;
      wr_en          <= 1'b0;
      wr_data        <= '0;
    end else begin
      wr_en <= 1'b0;
      if (rx_ready && rx_byte < 8'hF8) begin  // real-time bytes fall through untouched
        if (rx_byte[7]) begin
          running_status <= (rx_byte < 8'hF0) ? rx_byte : 8'h00;
          pstate         <= (rx_byte < 8'hF0) ? P_DATA1 : P_WAIT;
        end else if (pstate == P_DATA2) begin
          pstate <= P_WAIT;
          if ((rs_hi == NOTE_OFF || rs_hi == NOTE_ON) &&
              CHANNEL_MASK[running_status[3:0]]) begin
            wr_en            <= 1'b1;
            wr_data.is_on    <= (rs_hi == NOTE_ON) && (rx_byte[6:0] != 7'd0);
            wr_data.channel  <= running_status[3:0];
            wr_data.velocity <= rx_byte[6:0];
            wr_data.note     <= data1;
          end
        end else if (pstate == P_DATA1 || running_status != 8'h00) begin
          // First data byte, either explicit or under running status.
          data1  <= rx_byte[6:0];
          pstate <= is_single_data(rs_hi) ? P_WAIT : P_DATA2;
        end
      end
    end
  end

  // Event queue
  midi_event_t   mem [FIFO_DEPTH];
  midi_event_t   head;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          head_valid;
  logic          full;
  logic          pop;
  logic          push;

  assign head_valid = (count != '0);
  assign full       = (count == (AW+1)'(FIFO_DEPTH));
  assign pop        = head_valid && ev.ev_ready;
  assign push       = wr_en && (!full || pop);  // a same-cycle pop frees the slot
  assign head       = mem[rd_ptr];

  // Head fields are masked so they read 0 whenever the queue is empty.
  assign ev.ev_valid    = head_valid;
  assign ev.ev_note     = head_valid ? head.note     : '0;
  assign ev.ev_velocity = head_valid ? head.velocity : '0;
  assign ev.ev_channel  = head_valid ? head.channel  : '0;
  assign ev.ev_is_on    = head_valid && head.is_on;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      overflow <= wr_en && full && !pop;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: tb/tb_midi_rx_parser.sv
module tb_midi_rx_parser;
  import midi_pkg::*;

  localparam int          CLK_HZ  = 3_125_000;
  localparam int          BAUD    = 31250;
  localparam int          BT      = CLK_HZ / BAUD;  // 100 cycles per bit
  localparam logic [15:0] MASK_A  = 16'hFFFF;
  localparam logic [15:0] MASK_B  = 16'h0001;
  localparam int          DEPTH_A = 4;
  localparam int          DEPTH_B = 2;
  localparam int          DEPTH_S = 16;  // scratch model only

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_a, reset_b, rx_a, rx_b;
  midi_rx_parser_if if_a ();
  midi_rx_parser_if if_b ();
  logic       ovf_a, fe_a, rdy_a, ovf_b, fe_b, rdy_b;
  logic [7:0] byte_a, byte_b;
  logic [1:0] rxs_a, ps_a, rxs_b, ps_b;

  midi_rx_parser #(.CLOCK_FREQ(CLK_HZ), .BAUD_RATE(BAUD), .CHANNEL_MASK(MASK_A),
                   .FIFO_DEPTH(DEPTH_A)) dut_a (
    .clk(clk), .reset(reset_a), .uart_rx(rx_a), .ev(if_a), .overflow(ovf_a),
    .framing_error(fe_a), .debug_uart_byte(byte_a), .debug_uart_ready(rdy_a),
    .debug_rx_state(rxs_a), .debug_parse_state(ps_a));

  midi_rx_parser #(.CLOCK_FREQ(CLK_HZ), .BAUD_RATE(BAUD), .CHANNEL_MASK(MASK_B),
                   .FIFO_DEPTH(DEPTH_B)) dut_b (
    .clk(clk), .reset(reset_b), .uart_rx(rx_b), .ev(if_b), .overflow(ovf_b),
    .framing_error(fe_b), .debug_uart_byte(byte_b), .debug_uart_ready(rdy_b),
    .debug_rx_state(rxs_b), .debug_parse_state(ps_b));

  // ---------------- scoreboard state ----------------
  int total = 0;
  int bad   = 0;
  logic [EVENT_W-1:0] exp_q_a[$];
  logic [EVENT_W-1:0] exp_q_b[$];
  logic [EVENT_W-1:0] exp_q_s[$];
  logic [7:0]         dbg_q_a[$];
  logic [7:0]         dbg_q_b[$];
  int exp_ovf[3];
  int exp_fe[3];
  int seen_ovf[3];
  int seen_fe[3];

  // Message-level model: index 0 = dut_a, 1 = dut_b, 2 = scratch.
  logic [7:0] rs_m[3];
  int         dcnt_m[3];
  logic [6:0] d0_m[3];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [EVENT_W-1:0] ev_word(input logic on, input logic [3:0] ch,
                                                 input logic [6:0] vel, input logic [6:0] note);
    return {on, ch, vel, note};
  endfunction

  task automatic model_reset(input int w);
    rs_m[w]   = 8'h00;
    dcnt_m[w] = 0;
    d0_m[w]   = 7'd0;
  endtask

  task automatic model_emit(input int w, input logic [EVENT_W-1:0] e, input logic [3:0] ch);
    logic [15:0] mask;
    mask = (w == 1) ? MASK_B : MASK_A;
    if (!mask[ch]) return;
    case (w)
      0: if (exp_q_a.size() >= DEPTH_A) exp_ovf[0]++; else exp_q_a.push_back(e);
      1: if (exp_q_b.size() >= DEPTH_B) exp_ovf[1]++; else exp_q_b.push_back(e);
      default: if (exp_q_s.size() >= DEPTH_S) exp_ovf[2]++; else exp_q_s.push_back(e);
    endcase
  endtask

  task automatic model_byte(input int w, input logic [7:0] b);
    int         need;
    logic [3:0] hi;
    if (b >= 8'hF8) return;
    if (b[7]) begin
      rs_m[w]   = (b < 8'hF0) ? b : 8'h00;
      dcnt_m[w] = 0;
      return;
    end
    if (rs_m[w] == 8'h00) return;
    hi   = rs_m[w][7:4];
    need = (hi == 4'hC || hi == 4'hD) ? 1 : 2;
    dcnt_m[w]++;
    if (dcnt_m[w] == 1) d0_m[w] = b[6:0];
    if (dcnt_m[w] < need) return;
    dcnt_m[w] = 0;
    if (hi != 4'h8 && hi != 4'h9) return;
    model_emit(w, ev_word(hi == 4'h9 && b[6:0] != 7'd0, rs_m[w][3:0], b[6:0], d0_m[w]),
               rs_m[w][3:0]);
  endtask

  // ---------------- driver tasks ----------------
  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_line(input int w, input logic v);
    if (w == 0) rx_a = v; else rx_b = v;
  endtask

  task automatic send_byte(input int w, input logic [7:0] b, input logic stop);
    if (stop) begin
      model_byte(w, b);
      if (w == 0) dbg_q_a.push_back(b); else dbg_q_b.push_back(b);
    end else begin
      exp_fe[w]++;
    end
    set_line(w, 1'b0);
    wait_cycles(BT);
    for (int i = 0; i < 8; i++) begin
      set_line(w, b[i]);
      wait_cycles(BT);
    end
    set_line(w, stop);
    wait_cycles(BT);
    set_line(w, 1'b1);
    wait_cycles(BT);
  endtask

  // ---------------- compare process ----------------
  logic vprev_a = 1'b0;
  int   since_a = 1000;

  always @(negedge clk) begin
    if (!reset_a) begin
      since_a = rdy_a ? 0 : since_a + 1;
      if (if_a.ev_valid && !vprev_a) chk("ev_latency_a", since_a, 2);
      vprev_a = if_a.ev_valid;
      if (if_a.ev_valid && if_a.ev_ready) begin
        chk("ev_expected_a", 32'(exp_q_a.size() != 0), 1);
        if (exp_q_a.size() != 0)
          chk("ev_a", ev_word(if_a.ev_is_on, if_a.ev_channel, if_a.ev_velocity, if_a.ev_note),
              exp_q_a.pop_front());
      end
      if (ovf_a) seen_ovf[0]++;
      if (fe_a)  seen_fe[0]++;
      if (rdy_a) begin
        chk("dbg_expected_a", 32'(dbg_q_a.size() != 0), 1);
        if (dbg_q_a.size() != 0) chk("dbg_byte_a", byte_a, dbg_q_a.pop_front());
      end
    end else begin
      vprev_a = 1'b0;
    end
    if (!reset_b) begin
      if (if_b.ev_valid && if_b.ev_ready) begin
        chk("ev_expected_b", 32'(exp_q_b.size() != 0), 1);
        if (exp_q_b.size() != 0)
          chk("ev_b", ev_word(if_b.ev_is_on, if_b.ev_channel, if_b.ev_velocity, if_b.ev_note),
              exp_q_b.pop_front());
      end
      if (ovf_b) seen_ovf[1]++;
      if (fe_b)  seen_fe[1]++;
      if (rdy_b) begin
        chk("dbg_expected_b", 32'(dbg_q_b.size() != 0), 1);
        if (dbg_q_b.size() != 0) chk("dbg_byte_b", byte_b, dbg_q_b.pop_front());
      end
    end
  end

  task automatic check_all_zero_a(input string tag);
    chk({tag, "_valid"},   if_a.ev_valid, 0);
    chk({tag, "_note"},    if_a.ev_note, 0);
    chk({tag, "_vel"},     if_a.ev_velocity, 0);
    chk({tag, "_ch"},      if_a.ev_channel, 0);
    chk({tag, "_on"},      if_a.ev_is_on, 0);
    chk({tag, "_ovf"},     ovf_a, 0);
    chk({tag, "_fe"},      fe_a, 0);
    chk({tag, "_byte"},    byte_a, 0);
    chk({tag, "_rdy"},     rdy_a, 0);
    chk({tag, "_rxstate"}, rxs_a, 0);
    chk({tag, "_pstate"},  ps_a, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    for (int i = 0; i < 3; i++) begin
      model_reset(i);
      exp_ovf[i] = 0; exp_fe[i] = 0; seen_ovf[i] = 0; seen_fe[i] = 0;
    end
    rx_a = 1'b1; rx_b = 1'b1;
    if_a.ev_ready = 1'b1; if_b.ev_ready = 1'b1;
    reset_a = 1'b1; reset_b = 1'b1;
    wait_cycles(5);
    check_all_zero_a("rst0");
    reset_a = 1'b0; reset_b = 1'b0;
    wait_cycles(20);

    // Pin the model with hand-computed events.
    model_byte(2, 8'h93); model_byte(2, 8'h3C); model_byte(2, 8'h40);
    chk("model_on_ch3", exp_q_s.pop_front(), ev_word(1'b1, 4'd3, 7'd64, 7'd60));
    model_byte(2, 8'h90); model_byte(2, 8'h3C); model_byte(2, 8'h40);
    model_byte(2, 8'h3E); model_byte(2, 8'h00);
    chk("model_on_ch0", exp_q_s.pop_front(), ev_word(1'b1, 4'd0, 7'd64, 7'd60));
    chk("model_rs_off", exp_q_s.pop_front(), ev_word(1'b0, 4'd0, 7'd0, 7'd62));
    model_byte(2, 8'h90); model_byte(2, 8'hF8); model_byte(2, 8'h3C);
    model_byte(2, 8'hFE); model_byte(2, 8'h50);
    chk("model_rt", exp_q_s.pop_front(), ev_word(1'b1, 4'd0, 7'd80, 7'd60));

    // dut_a: basic note-on, running status, real-time interleave, framing error.
    send_byte(0, 8'h93, 1); send_byte(0, 8'h3C, 1); send_byte(0, 8'h40, 1);
    send_byte(0, 8'h90, 1); send_byte(0, 8'h3C, 1); send_byte(0, 8'h40, 1);
    send_byte(0, 8'h3E, 1); send_byte(0, 8'h00, 1);
    send_byte(0, 8'h90, 1); send_byte(0, 8'hF8, 1); send_byte(0, 8'h3C, 1);
    send_byte(0, 8'hFE, 1); send_byte(0, 8'h50, 1);
    send_byte(0, 8'h3C, 0);
    // 8n note-off, one-byte program change under running status, sysex clear.
    send_byte(0, 8'h85, 1); send_byte(0, 8'h40, 1); send_byte(0, 8'h00, 1);
    send_byte(0, 8'hC2, 1); send_byte(0, 8'h05, 1); send_byte(0, 8'h07, 1);
    send_byte(0, 8'hF0, 1); send_byte(0, 8'h10, 1);
    send_byte(0, 8'h80, 1); send_byte(0, 8'h30, 1); send_byte(0, 8'h25, 1);
    wait_cycles(50);

    // dut_b: masked channel, then overflow with the consumer stalled.
    send_byte(1, 8'h85, 1); send_byte(1, 8'h40, 1); send_byte(1, 8'h00, 1);
    wait_cycles(50);
    chk("b_masked_valid", if_b.ev_valid, 0);
    if_b.ev_ready = 1'b0;
    send_byte(1, 8'h90, 1); send_byte(1, 8'h3C, 1); send_byte(1, 8'h40, 1);
    send_byte(1, 8'h3D, 1); send_byte(1, 8'h41, 1);
    send_byte(1, 8'h3E, 1); send_byte(1, 8'h42, 1);
    wait_cycles(50);
    chk("b_hold_valid", if_b.ev_valid, 1);
    chk("b_hold_note", if_b.ev_note, 60);
    chk("b_hold_vel", if_b.ev_velocity, 64);
    chk("b_hold_ch", if_b.ev_channel, 0);
    chk("b_hold_on", if_b.ev_is_on, 1);
    chk("b_ovf_pulses", seen_ovf[1], 1);
    if_b.ev_ready = 1'b1;
    wait_cycles(20);
    chk("b_drained_valid", if_b.ev_valid, 0);

    // dut_a: reset in the middle of a data bit of 0x90.
    set_line(0, 1'b0);
    wait_cycles(BT);
    for (int i = 0; i < 4; i++) begin
      set_line(0, 1'b0);
      wait_cycles(BT);
    end
    set_line(0, 1'b1);  // bit 4 of 0x90
    wait_cycles(BT / 2);
    reset_a = 1'b1;
    wait_cycles(3);
    check_all_zero_a("rst_mid");
    rx_a = 1'b1;
    wait_cycles(20);
    model_reset(0);
    reset_a = 1'b0;
    wait_cycles(200);
    send_byte(0, 8'h3C, 1); send_byte(0, 8'h40, 1);
    wait_cycles(200);
    chk("a_after_rst_valid", if_a.ev_valid, 0);

    // Final accounting.
    chk("a_events_left", exp_q_a.size(), 0);
    chk("b_events_left", exp_q_b.size(), 0);
    chk("a_bytes_left", dbg_q_a.size(), 0);
    chk("b_bytes_left", dbg_q_b.size(), 0);
    chk("a_fe_count", seen_fe[0], exp_fe[0]);
    chk("b_fe_count", seen_fe[1], exp_fe[1]);
    chk("a_fe_literal", seen_fe[0], 1);
    chk("a_ovf_count", seen_ovf[0], exp_ovf[0]);
    chk("b_ovf_count", seen_ovf[1], exp_ovf[1]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
